// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock. Results land on q (LO) / r (HI) with a one-cycle
// done pulse and are held until the next division completes.
// Optional feature macro: DIV_EARLY_EXIT_EN -- when defined, the dividend is
// pre-shifted by the leading-zero count lz so only 32-lz iterations are run.
// When undefined, lz is ignored and every non-divide-by-zero operation takes
// 32 iterations. Results are identical in both builds.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [5:0]  lz,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_next_s;

  logic [31:0] d_r;        // divisor magnitude
  logic [31:0] p_r;        // partial remainder (always < D between steps)
  logic [31:0] sh_r;       // dividend bits out / quotient bits in
  logic [5:0]  n_r;        // iterations remaining
  logic [31:0] dvd_r;      // dividend as captured, for divide-by-zero
  logic        neg_q_r;
  logic        neg_r_r;
  logic        dzero_r;
  logic        ovf_r;
  logic [31:0] q_r;
  logic [31:0] r_r;
  logic        busy_r;
  logic        done_r;

  logic [31:0] mag_a_s;
  logic [31:0] mag_b_s;
  logic [5:0]  n_load_s;
  logic [31:0] sh_load_s;
  logic [32:0] p_shift_s;
  logic [32:0] p_step_s;
  logic        q_bit_s;
  logic [31:0] sh_step_s;
  logic [31:0] fix_q_s;
  logic [31:0] fix_r_s;

  // Two's complement magnitude when signed and negative, else the raw value.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic sgn);
    logic [31:0] m;
    if (sgn && x[31]) begin
      m = 32'd0 - x;
    end else begin
      m = x;
    end
    return m;
  endfunction

`ifdef DIV_EARLY_EXIT_EN
  logic [5:0]  lz_sat_s;

  // Operand load values: saturate lz and pre-shift the dividend magnitude.
  always_comb begin
    mag_a_s   = magnitude(dividend, is_signed);
    mag_b_s   = magnitude(divisor, is_signed);
    lz_sat_s  = (lz > 6'd32) ? 6'd32 : lz;
    n_load_s  = 6'd32 - lz_sat_s;
    if (lz_sat_s == 6'd32) begin
      sh_load_s = 32'd0;
    end else begin
      sh_load_s = mag_a_s << lz_sat_s;
    end
  end
`else
  logic unused_lz_s;
  assign unused_lz_s = ^lz;

  // Operand load values: no pre-shift, always the full 32 iterations.
  always_comb begin
    mag_a_s   = magnitude(dividend, is_signed);
    mag_b_s   = magnitude(divisor, is_signed);
    n_load_s  = 6'd32;
    sh_load_s = mag_a_s;
  end
`endif

  // One restoring step: shift {P,shift} left, trial-subtract D (33-bit unsigned).
  always_comb begin
    p_shift_s = {p_r, sh_r[31]};
    if (p_shift_s >= {1'b0, d_r}) begin
      p_step_s = p_shift_s - {1'b0, d_r};
      q_bit_s  = 1'b1;
    end else begin
      p_step_s = p_shift_s;
      q_bit_s  = 1'b0;
    end
    sh_step_s = {sh_r[30:0], q_bit_s};
  end

  // Final result with sign fix-up and the special cases.
  always_comb begin
    if (dzero_r) begin
      fix_q_s = 32'hFFFF_FFFF;
      fix_r_s = dvd_r;
    end else if (ovf_r) begin
      fix_q_s = 32'h8000_0000;
      fix_r_s = 32'd0;
    end else begin
      fix_q_s = neg_q_r ? (32'd0 - sh_r) : sh_r;
      fix_r_s = neg_r_r ? (32'd0 - p_r) : p_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if ((n_load_s != 6'd0) && (divisor != 32'd0)) begin
            state_next_s = S_RUN;
          end else begin
            state_next_s = S_FIX;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (n_r == 6'd1) begin
          state_next_s = S_FIX;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_FIX:   state_next_s = S_DONE;
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_r     <= 32'd0;
      p_r     <= 32'd0;
      sh_r    <= 32'd0;
      n_r     <= 6'd0;
      dvd_r   <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dzero_r <= 1'b0;
      ovf_r   <= 1'b0;
      q_r     <= 32'd0;
      r_r     <= 32'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            d_r     <= mag_b_s;
            p_r     <= 32'd0;
            sh_r    <= sh_load_s;
            n_r     <= n_load_s;
            dvd_r   <= dividend;
            neg_q_r <= is_signed & (dividend[31] ^ divisor[31]);
            neg_r_r <= is_signed & dividend[31];
            dzero_r <= (divisor == 32'd0);
            ovf_r   <= is_signed && (dividend == 32'h8000_0000) &&
                       (divisor == 32'hFFFF_FFFF);
          end
        end
        S_RUN: begin
          p_r  <= p_step_s[31:0];
          sh_r <= sh_step_s;
          n_r  <= n_r - 6'd1;
        end
        S_FIX: begin
          q_r <= fix_q_s;
          r_r <= fix_r_s;
        end
        default: begin
          n_r <= n_r;
        end
      endcase
    end
  end

  // Registered status flags, decoded from the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == S_RUN) || (state_next_s == S_FIX);
      done_r <= (state_next_s == S_DONE);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign q    = q_r;
  assign r    = r_r;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: the driver pushes expected results, a
// negedge monitor pops and compares whenever done is high.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = 32'd0;
  logic [31:0] divisor = 32'd0;
  logic [5:0]  lz = 6'd0;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int op_id = 0;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .lz        (lz),
    .busy      (busy),
    .done      (done),
    .q         (q),
    .r         (r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_lat(input logic [31:0] b, input logic [5:0] l);
    int early;
    int n;
`ifdef DIV_EARLY_EXIT_EN
    early = 1;
`else
    early = 0;
`endif
    if (b == 32'd0) return 2;
    if (early == 0) return 34;
    n = (l > 6'd32) ? 0 : 32 - int'(l);
    if (n == 0) return 2;
    return n + 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Drive one accepted start (called in IDLE) and record the expectation.
  task automatic send(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] l, input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b; lz = l;
    op_id++;
    e.id = op_id; e.q = eq; e.r = er; e.t0 = cyc; e.lat = exp_lat(b, l);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_cycle1", {31'd0, busy}, 32'd1);
  endtask

  // Pulse start for one cycle without expecting it to be accepted.
  task automatic poke(input logic [31:0] a, input logic [31:0] b, input logic [5:0] l);
    start = 1'b1; is_signed = 1'b0; dividend = a; divisor = b; lz = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) until done is seen, returning #1 into the done cycle.
  task automatic wait_done();
    int seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (seen == 0) begin
      errors++;
      checks++;
      $display("FAIL wait_done: got no done expected done within 40 cycles");
    end
  endtask

  // Monitor: compare every done against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (q !== e.q || r !== e.r || (cyc - e.t0) != e.lat || busy !== 1'b0) begin
          errors++;
          $display("FAIL op%0d: got q=%h r=%h lat=%0d busy=%b expected q=%h r=%h lat=%0d busy=0",
                   e.id, q, r, cyc - e.t0, busy, e.q, e.r, e.lat);
        end
      end
    end
  end

  initial begin
    // reset state
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // directed vectors: sgn, dividend, divisor, lz, q, r
    send(1'b0, 32'd100, 32'd7, 6'd25, 32'd14, 32'd2);                       wait_done();
    send(1'b1, 32'hFFFF_FFF9, 32'd2, 6'd29, 32'hFFFF_FFFD, 32'hFFFF_FFFF);   wait_done();
    send(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 6'd0, 32'h8000_0000, 32'd0);   wait_done();
    send(1'b0, 32'd1234, 32'd0, 6'd21, 32'hFFFF_FFFF, 32'd1234);            wait_done();
    send(1'b1, 32'd0, 32'd5, 6'd32, 32'd0, 32'd0);                          wait_done();
    send(1'b1, 32'd7, 32'hFFFF_FFFE, 6'd29, 32'hFFFF_FFFD, 32'd1);          wait_done();
    send(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 6'd29, 32'd3, 32'hFFFF_FFFF);  wait_done();
    send(1'b1, 32'hFFFF_FFFB, 32'd0, 6'd29, 32'hFFFF_FFFF, 32'hFFFF_FFFB);  wait_done();
    send(1'b0, 32'hFFFF_FFFF, 32'd1, 6'd0, 32'hFFFF_FFFF, 32'd0);           wait_done();
    send(1'b0, 32'd5, 32'd10, 6'd29, 32'd0, 32'd5);                         wait_done();
    send(1'b0, 32'd0, 32'd9, 6'd63, 32'd0, 32'd0);                          wait_done();

    // start during RUN and during DONE is ignored; next IDLE start accepted
    send(1'b0, 32'd100, 32'd7, 6'd25, 32'd14, 32'd2);
    poke(32'd50, 32'd5, 6'd26);
    wait_done();
    start = 1'b1; is_signed = 1'b0; dividend = 32'd99; divisor = 32'd9; lz = 6'd25;
    send(1'b0, 32'd50, 32'd5, 6'd26, 32'd10, 32'd0);
    wait_done();

    // asynchronous reset mid-RUN discards the operation
    send(1'b0, 32'd1000000, 32'd3, 6'd12, 32'd333333, 32'd1);
    repeat (9) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_q", q, 32'd0);
    chk("midrst_r", r, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send(1'b0, 32'hFFFF_FFFF, 32'd3, 6'd0, 32'h5555_5555, 32'd0);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
